mem_line_latency: RTL and testbench

//  Behavioural line-wide main-memory model with base-address mapping and a fixed

---
 rtl/mem_model_pkg.sv | 20 ++
 rtl/mem_lat_ctrl.sv | 67 ++++++
 rtl/mem_line_latency.sv | 123 ++++++++++++
 tb/tb_mem_line_latency.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_model_pkg.sv
// Shared definitions for the line-wide latency memory model: controller state
// encoding and a constant-evaluable ceil(log2) helper.
package mem_model_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } mem_state_e;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/mem_lat_ctrl.sv
// Access sequencer: accepts a request in IDLE, waits out the fixed latency,
// then raises ready for exactly one cycle.
module mem_lat_ctrl
    import mem_model_pkg::*;
#(
    parameter int LATENCY = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req,
    output logic accept,
    output logic commit,
    output logic ready
);

    localparam int LAT_BITS = (clog2(LATENCY) < 1) ? 1 : clog2(LATENCY);
    localparam logic [LAT_BITS-1:0] LAT_LOAD = LAT_BITS'(LATENCY - 1);

    mem_state_e          state_q, state_d;
    logic [LAT_BITS-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // commit marks the edge that enters DONE; the datapath updates on it
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        commit  = 1'b0;
        ready   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    accept = 1'b1;
                    cnt_d  = LAT_LOAD;
                    if (LATENCY == 1) begin
                        state_d = ST_DONE;
                        commit  = 1'b1;
                    end else begin
                        state_d = ST_BUSY;
                    end
                end
            end
            ST_BUSY: begin
                cnt_d = cnt_q - LAT_BITS'(1);
                if (cnt_q == LAT_BITS'(1)) begin
                    state_d = ST_DONE;
                    commit  = 1'b1;
                end
            end
            ST_DONE: begin
                ready   = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: rtl/mem_line_latency.sv
// Line-wide main-memory model behind the L1 controller: base-relative line
// mapping, fixed access latency, error reporting and saturating access counters.
module mem_line_latency
    import mem_model_pkg::*;
#(
    parameter int  WORD_BITS   = 32,
    parameter int  LINE_WORDS  = 4,
    parameter int  DEPTH_LINES = 32,
    parameter int  LATENCY     = 8,
    parameter int  CNT_BITS    = 16,
    localparam int LINE_BITS   = WORD_BITS * LINE_WORDS
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [31:0]          offset,
    input  logic                 mem_read,
    input  logic                 mem_write,
    input  logic [31:0]          mem_addr,
    input  logic [LINE_BITS-1:0] mem_wdata,
    output logic [LINE_BITS-1:0] mem_rdata,
    output logic                 mem_ready,
    output logic                 mem_err,
    output logic [CNT_BITS-1:0]  rd_count,
    output logic [CNT_BITS-1:0]  wr_count
);

    localparam int OFF_BITS = clog2(LINE_WORDS * WORD_BITS / 8);
    localparam int IDX_BITS = clog2(DEPTH_LINES);

    logic                 accept, commit, ready;
    logic [31:0]          base_q, addr_q;
    logic [LINE_BITS-1:0] wdata_q;
    logic                 rd_q, wr_q;
    logic [31:0]          op_addr;
    logic [LINE_BITS-1:0] op_wdata;
    logic                 op_rd, op_wr;
    logic [31:0]          line_full;
    logic                 bad, store_en;
    logic [LINE_BITS-1:0] line_bus [DEPTH_LINES];
    logic [LINE_BITS-1:0] rdata_q, rdata_d;
    logic [CNT_BITS-1:0]  rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d;

    mem_lat_ctrl #(.LATENCY(LATENCY)) u_ctrl (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (mem_read | mem_write),
        .accept (accept),
        .commit (commit),
        .ready  (ready)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_q  <= offset;
            addr_q  <= '0;
            wdata_q <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
        end else if (accept) begin
            addr_q  <= mem_addr;
            wdata_q <= mem_wdata;
            rd_q    <= mem_read;
            wr_q    <= mem_write;
        end
    end

    // With a one-cycle latency accept and commit share an edge, so the live request is used
    assign op_addr  = accept ? mem_addr  : addr_q;
    assign op_wdata = accept ? mem_wdata : wdata_q;
    assign op_rd    = accept ? mem_read  : rd_q;
    assign op_wr    = accept ? mem_write : wr_q;

    assign line_full = (op_addr - base_q) >> OFF_BITS;
    assign bad       = (op_rd & op_wr) | (op_addr < base_q) | (line_full >= 32'(DEPTH_LINES));
    assign store_en  = commit & op_wr & ~bad;

    for (genvar gi = 0; gi < DEPTH_LINES; gi++) begin : g_line
        logic [LINE_BITS-1:0] line_q;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                line_q <= '0;
            end else if (store_en && (line_full[IDX_BITS-1:0] == IDX_BITS'(gi))) begin
                line_q <= op_wdata;
            end
        end
        assign line_bus[gi] = line_q;
    end

    always_comb begin
        rdata_d  = rdata_q;
        rd_cnt_d = rd_cnt_q;
        wr_cnt_d = wr_cnt_q;
        if (commit) begin
            if (bad) begin
                rdata_d = '0;
            end else if (op_rd) begin
                rdata_d = line_bus[line_full[IDX_BITS-1:0]];
                if (rd_cnt_q != '1) rd_cnt_d = rd_cnt_q + CNT_BITS'(1);
            end else if (wr_cnt_q != '1) begin
                wr_cnt_d = wr_cnt_q + CNT_BITS'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q  <= '0;
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
        end else begin
            rdata_q  <= rdata_d;
            rd_cnt_q <= rd_cnt_d;
            wr_cnt_q <= wr_cnt_d;
        end
    end

    assign mem_rdata = rdata_q;
    assign mem_ready = ready;
    assign mem_err   = ready & bad;
    assign rd_count  = rd_cnt_q;
    assign wr_count  = wr_cnt_q;

endmodule

// File: tb/tb_mem_line_latency.sv
// Randomized bench for mem_line_latency against a transaction-level memory model,
// plus directed pins for latency, mapping, errors, reset abort and a LATENCY=1 build.
module tb_mem_line_latency;

    localparam int LAT = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int edge_n = 0;
    always @(posedge clk) edge_n <= edge_n + 1;

    int n_cmp = 0;
    int n_bad = 0;

    // main instance (default parameters)
    logic         rst_n = 1'b0;
    logic [31:0]  offset = 32'h1000;
    logic         rd = 1'b0, wr = 1'b0;
    logic [31:0]  addr = '0;
    logic [127:0] wdata = '0;
    logic [127:0] rdata;
    logic         ready, err;
    logic [15:0]  rdc, wrc;

    mem_line_latency dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .offset    (offset),
        .mem_read  (rd),
        .mem_write (wr),
        .mem_addr  (addr),
        .mem_wdata (wdata),
        .mem_rdata (rdata),
        .mem_ready (ready),
        .mem_err   (err),
        .rd_count  (rdc),
        .wr_count  (wrc)
    );

    // one-cycle latency, 2-bit counter instance
    logic [31:0]  offset2 = 32'h0;
    logic         rd2 = 1'b0, wr2 = 1'b0;
    logic [31:0]  addr2 = '0;
    logic [127:0] wdata2 = '0;
    logic [127:0] rdata2;
    logic         ready2, err2;
    logic [1:0]   rdc2, wrc2;

    mem_line_latency #(.LATENCY(1), .CNT_BITS(2)) dut2 (
        .clk       (clk),
        .rst_n     (rst_n),
        .offset    (offset2),
        .mem_read  (rd2),
        .mem_write (wr2),
        .mem_addr  (addr2),
        .mem_wdata (wdata2),
        .mem_rdata (rdata2),
        .mem_ready (ready2),
        .mem_err   (err2),
        .rd_count  (rdc2),
        .wr_count  (wrc2)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    // behavioural model: memory image, last read line, counters, one outstanding access
    logic [127:0] m_mem [32];
    logic [31:0]  m_base;
    logic [127:0] m_rdata;
    int           m_rd, m_wr;
    bit           pend_valid = 0;
    int           pend_done;
    logic         pend_rd, pend_wr;
    logic [31:0]  pend_addr;
    logic [127:0] pend_wdata;
    int           acc_edge;
    int           last_ready_edge = -1;
    logic         last_err;
    bit           chk_en = 0;

    logic         exp_ready, exp_err;
    logic [31:0]  rel;

    // Requests driven before edge k complete in the cycle closed by edge k+LAT,
    // i.e. mem_ready is seen at the negedge following edge k+LAT-1.
    always @(negedge clk) begin
        if (chk_en) begin
            exp_ready = pend_valid && (edge_n == pend_done);
            exp_err   = 1'b0;
            if (exp_ready) begin
                pend_valid = 0;
                rel = pend_addr - m_base;
                exp_err = (pend_rd && pend_wr) || (pend_addr < m_base) || ((rel / 16) >= 32);
                if (exp_err) begin
                    m_rdata = '0;
                end else if (pend_rd) begin
                    m_rdata = m_mem[rel / 16];
                    if (m_rd < 65535) m_rd++;
                end else begin
                    m_mem[rel / 16] = pend_wdata;
                    if (m_wr < 65535) m_wr++;
                end
            end
            check("ready", 128'(ready), 128'(exp_ready));
            check("err", 128'(err), 128'(exp_err));
            check("rdata", rdata, m_rdata);
            check("rd_count", 128'(rdc), 128'(m_rd));
            check("wr_count", 128'(wrc), 128'(m_wr));
            if (ready) begin
                last_ready_edge = edge_n;
                last_err        = err;
            end
        end
    end

    task automatic apply_reset(input logic [31:0] off);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        offset = off;
        rd = 1'b0; wr = 1'b0; rd2 = 1'b0; wr2 = 1'b0;
        pend_valid = 0;
        for (int i = 0; i < 32; i++) m_mem[i] = '0;
        m_base = off; m_rdata = '0; m_rd = 0; m_wr = 0;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    task automatic access(input logic r, input logic w, input logic [31:0] a,
                          input logic [127:0] d, input bit hold);
        int done;
        @(negedge clk);
        rd = r; wr = w; addr = a; wdata = d;
        pend_rd = r; pend_wr = w; pend_addr = a; pend_wdata = d;
        acc_edge = edge_n + 1;
        done = edge_n + LAT;
        pend_done = done;
        pend_valid = 1;
        @(negedge clk);
        if (!hold) begin rd = 1'b0; wr = 1'b0; end
        while (edge_n < done) @(negedge clk);
        @(negedge clk);
        $display("txn rd=%0b wr=%0b addr=%h err=%0b rdata=%h rd_count=%0d wr_count=%0d",
                 r, w, a, last_err, rdata, rdc, wrc);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish, required finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [127:0] pat, pat2;
        int first_ready, done, r_sel, o_sel;
        logic [31:0] a;

        apply_reset(32'h1000);
        chk_en = 1;
        @(negedge clk);
        check("reset_ready", 128'(ready), 128'(0));
        check("reset_rdata", rdata, 128'(0));

        // 1: first read, exact latency
        access(1'b1, 1'b0, 32'h1000, '0, 0);
        check("t1_latency", 128'(last_ready_edge - acc_edge + 1), 128'(8));
        check("t1_err", 128'(last_err), 128'(0));
        check("t1_rdcount", 128'(rdc), 128'(1));

        // 2: write line 1, read back via unaligned address, line 0 untouched
        pat = {32'hDDDD_0004, 32'hCCCC_0003, 32'hBBBB_0002, 32'hAAAA_0001};
        access(1'b0, 1'b1, 32'h1010, pat, 0);
        access(1'b1, 1'b0, 32'h101C, '0, 0);
        check("t2_rdata", rdata, pat);
        access(1'b1, 1'b0, 32'h1000, '0, 0);
        check("t2_line0", rdata, 128'(0));

        // 3: out-of-range below base and past the last line
        access(1'b1, 1'b0, 32'h0FFC, '0, 0);
        check("t3_err_low", 128'(last_err), 128'(1));
        access(1'b1, 1'b0, 32'h1200, '0, 0);
        check("t3_err_high", 128'(last_err), 128'(1));
        check("t3_rdata", rdata, 128'(0));
        check("t3_rdcount", 128'(rdc), 128'(3));
        check("t3_wrcount", 128'(wrc), 128'(1));
        access(1'b1, 1'b0, 32'h1014, '0, 0);
        check("t3_storage", rdata, pat);

        // 4: read&write held through IDLE -> second access
        access(1'b1, 1'b1, 32'h1000, pat, 1);
        check("t4_err", 128'(last_err), 128'(1));
        first_ready = last_ready_edge;
        pend_valid = 1;
        done = edge_n + LAT;
        pend_done = done;
        @(negedge clk);
        rd = 1'b0; wr = 1'b0;
        while (edge_n < done) @(negedge clk);
        @(negedge clk);
        check("t4_spacing", 128'(last_ready_edge - first_ready), 128'(LAT + 1));
        check("t4_err2", 128'(last_err), 128'(1));

        // 5: reset in the 4th cycle of a write aborts it; new offset applies
        @(negedge clk);
        wr = 1'b1; addr = 32'h1020; wdata = ~pat;
        pend_rd = 1'b0; pend_wr = 1'b1; pend_addr = 32'h1020; pend_wdata = ~pat;
        pend_done = edge_n + LAT; pend_valid = 1;
        @(negedge clk);
        wr = 1'b0;
        repeat (2) @(negedge clk);
        apply_reset(32'h2000);
        repeat (LAT + 2) @(negedge clk);
        access(1'b1, 1'b0, 32'h2020, '0, 0);
        check("t5_err", 128'(last_err), 128'(0));
        check("t5_rdata", rdata, 128'(0));
        check("t5_wrcount", 128'(wrc), 128'(0));
        access(1'b1, 1'b0, 32'h1010, '0, 0);
        check("t5_oldbase_err", 128'(last_err), 128'(1));

        // randomized traffic around the new base
        for (int n = 0; n < 150; n++) begin
            r_sel = $urandom_range(0, 9);
            o_sel = $urandom_range(0, 19);
            if (r_sel == 0)      a = 32'h2000 - $urandom_range(1, 64);
            else if (r_sel == 1) a = 32'h2200 + $urandom_range(0, 200);
            else                 a = 32'h2000 + $urandom_range(0, 511);
            pat2 = {$urandom, $urandom, $urandom, $urandom};
            if (o_sel == 0)      access(1'b1, 1'b1, a, pat2, 0);
            else if (o_sel < 10) access(1'b0, 1'b1, a, pat2, 0);
            else                 access(1'b1, 1'b0, a, pat2, 0);
        end

        // 6: LATENCY=1 / CNT_BITS=2 build
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            rd2 = 1'b1; addr2 = 32'h0;
            @(negedge clk);
            check("t6_ready", 128'(ready2), 128'(1));
            check("t6_err", 128'(err2), 128'(0));
            check("t6_rdcount", 128'(rdc2), 128'((i + 1 > 3) ? 3 : i + 1));
            rd2 = 1'b0;
            @(negedge clk);
            check("t6_ready_low", 128'(ready2), 128'(0));
            $display("txn lat1 read %0d rd_count=%0d", i, rdc2);
        end
        @(negedge clk);
        wr2 = 1'b1; addr2 = 32'h24; wdata2 = pat;
        @(negedge clk);
        check("t6_wready", 128'(ready2), 128'(1));
        check("t6_wrcount", 128'(wrc2), 128'(1));
        wr2 = 1'b0;
        @(negedge clk);
        rd2 = 1'b1; addr2 = 32'h20;
        @(negedge clk);
        check("t6_rdata", rdata2, pat);
        check("t6_rdsat", 128'(rdc2), 128'(3));
        rd2 = 1'b0;
        $display("txn lat1 write/read rdata=%h", rdata2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
